// File: rtl/wb_interconnect_wrr_arb.sv
// Weighted round-robin Wishbone arbiter: N_REQ masters, per-master beat quota, registered one-hot grant.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module wb_interconnect_wrr_arb #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WEIGHT_W  = 4,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic                        xfer,
  input  logic [N_REQ*WEIGHT_W-1:0]   weights,
  output logic [N_REQ-1:0]            gnt,
  output logic [$clog2(N_REQ)-1:0]    gnt_id,
  output logic                        gnt_valid,
  output logic                        timeout
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state;
  logic [ID_W-1:0]     last_id;
  logic [WEIGHT_W-1:0] cnt;
  logic                found;
  logic [ID_W-1:0]     sel;
  logic [WEIGHT_W-1:0] sel_w;
  logic [WEIGHT_W-1:0] cur_w;
  logic [WEIGHT_W-1:0] sel_raw;
  logic [WEIGHT_W-1:0] cur_raw;
  logic                wd_fire;

  // Round-robin search starting just after last_id; wrap compares against N_REQ-1
  // explicitly so non-power-of-2 N_REQ never indexes past the last master.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = (32'(last_id) + 1 >= N_REQ) ? 0 : 32'(last_id) + 1;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[ID_W-1:0];
      end
      idx = (idx + 1 >= N_REQ) ? 0 : idx + 1;
    end
  end

  always_comb begin
    sel_raw = weights[sel*WEIGHT_W +: WEIGHT_W];
    cur_raw = weights[gnt_id*WEIGHT_W +: WEIGHT_W];
    sel_w   = (sel_raw == '0) ? WEIGHT_W'(1) : sel_raw;
    cur_w   = (cur_raw == '0) ? WEIGHT_W'(1) : cur_raw;
  end

  assign gnt_valid = |gnt;

`ifdef ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_PRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 timeout_q;

  // Fires on the edge where the counter would reach all-ones.
  assign wd_fire = (state == GRANT) && req[gnt_id] && !xfer && (wd_cnt == WD_PRE);
  assign timeout = timeout_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      if (state != GRANT || xfer || wd_fire)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
    end
  end
`else
  logic [TIMEOUT_W-1:0] unused_timeout_w;
  assign unused_timeout_w = '0;
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      last_id <= LAST_ID;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= N_REQ'(1) << sel;
            gnt_id  <= sel;
            last_id <= sel;
            cnt     <= sel_w;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_id] || wd_fire) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (xfer && cnt == WEIGHT_W'(1)) begin
            // Quota exhausted: yield only if someone else is waiting, else refill.
            if (|(req & ~gnt)) begin
              gnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cur_w;
            end
          end else if (xfer) begin
            cnt <= cnt - WEIGHT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
